// File: rtl/byte_packer_if.sv
// Byte-in / word-out bundle for byte_packer. The master side drives the byte stream
// and the downstream ready; the slave side is the packer itself.
interface byte_packer_if #(
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int LVLW = $clog2(FIFO_DEPTH) + 1;

    logic                 i_valid;
    logic [7:0]           iv_data;
    logic                 i_flush;
    logic                 i_ready;
    logic                 i_clr_ovf;
    logic                 o_valid;
    logic [8*LANES-1:0]   ov_data;
    logic [LANES-1:0]     ov_keep;
    logic [LVLW-1:0]      ov_level;
    logic                 o_overflow;

    modport master (
        output i_valid, iv_data, i_flush, i_ready, i_clr_ovf,
        input  o_valid, ov_data, ov_keep, ov_level, o_overflow
    );

    modport slave (
        input  i_valid, iv_data, i_flush, i_ready, i_clr_ovf,
        output o_valid, ov_data, ov_keep, ov_level, o_overflow
    );
endinterface

// File: rtl/byte_packer.sv
// Packs a qualified byte stream into LANES-byte words (first byte in lane 0) and
// queues completed words in a small FIFO behind a valid/ready output.

module byte_packer_lane #(
    parameter int LANE = 0,
    parameter int IDXW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IDXW-1:0] idx,
    input  logic            valid,
    input  logic [7:0]      din,
    input  logic            commit,
    output logic [7:0]      word_byte,
    output logic            keep
);
    localparam logic [IDXW-1:0] LANE_IDX = IDXW'(LANE);

    logic [7:0] held;
    logic       hit;
    logic       filled;

    assign hit    = valid && (idx == LANE_IDX);
    assign filled = idx > LANE_IDX;

    always_ff @(posedge clk) begin
        if (rst)
            held <= 8'h00;
        else if (commit)
            held <= 8'h00;
        else if (hit)
            held <= din;
    end

    // A byte arriving in the commit cycle bypasses the holding register.
    assign word_byte = hit ? din : (filled ? held : 8'h00);
    assign keep      = hit || filled;
endmodule

module byte_packer #(
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    byte_packer_if.slave  bus
);
    localparam int IDXW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVLW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [LANES-1:0][7:0] data;
        logic [LANES-1:0]      keep;
    } entry_t;

    logic [IDXW-1:0]       idx;
    logic                  last_lane;
    logic                  commit;
    logic [LANES-1:0][7:0] word_data;
    logic [LANES-1:0]      word_keep;

    assign last_lane = idx == IDXW'(LANES - 1);
    assign commit    = (bus.i_valid && last_lane) ||
                       (bus.i_flush && ((idx != '0) || bus.i_valid));

    always_ff @(posedge i_clk) begin
        if (i_rst)
            idx <= '0;
        else if (commit)
            idx <= '0;
        else if (bus.i_valid)
            idx <= idx + 1'b1;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        byte_packer_lane #(
            .LANE (k),
            .IDXW (IDXW)
        ) u_lane (
            .clk       (i_clk),
            .rst       (i_rst),
            .idx       (idx),
            .valid     (bus.i_valid),
            .din       (bus.iv_data),
            .commit    (commit),
            .word_byte (word_data[k]),
            .keep      (word_keep[k])
        );
    end

    entry_t          mem [FIFO_DEPTH];
    entry_t          head;
    logic [PTRW-1:0] rd_ptr;
    logic [PTRW-1:0] wr_ptr;
    logic [LVLW-1:0] level;
    logic            empty;
    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    logic            overflow;

    assign empty = level == '0;
    assign full  = level == LVLW'(FIFO_DEPTH);
    assign pop   = !empty && bus.i_ready;
    // A same-cycle pop frees the slot, so a full FIFO still accepts the word.
    assign push  = commit && (!full || pop);
    assign drop  = commit && full && !pop;

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= '{data: word_data, keep: word_keep};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (bus.i_clr_ovf)
                overflow <= 1'b0;
        end
    end

    assign head           = mem[rd_ptr];
    assign bus.o_valid    = !empty;
    assign bus.ov_data    = empty ? '0 : head.data;
    assign bus.ov_keep    = empty ? '0 : head.keep;
    assign bus.ov_level   = level;
    assign bus.o_overflow = overflow;
endmodule

// File: tb/tb_byte_packer.sv
// Directed bench for byte_packer: stimulus queues hand-computed words, a monitor
// compares every popped head word against the queue.
module tb_byte_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    byte_packer_if #(.LANES(4), .FIFO_DEPTH(4)) bus ();

    byte_packer #(.LANES(4), .FIFO_DEPTH(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: a pop happens on the next edge whenever o_valid && i_ready.
    always @(negedge clk) begin
        if (!rst && bus.o_valid && bus.i_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h, expected none", bus.ov_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pop_data", bus.ov_data, e.data);
                chk("pop_keep", 32'(bus.ov_keep), 32'(e.keep));
            end
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d, input logic f, input logic c);
        bus.i_valid   = v;
        bus.iv_data   = d;
        bus.i_flush   = f;
        bus.i_clr_ovf = c;
        @(posedge clk);
        #1;
        bus.i_valid   = 1'b0;
        bus.iv_data   = 8'h00;
        bus.i_flush   = 1'b0;
        bus.i_clr_ovf = 1'b0;
    endtask

    task automatic word4(input logic [31:0] w);
        for (int k = 0; k < 4; k++) cyc(1'b1, w[8*k +: 8], 1'b0, 1'b0);
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k);
        sb.push_back('{data: d, keep: k});
    endtask

    task automatic drain(input string name);
        bus.i_ready = 1'b1;
        for (int n = 0; n < 40 && (sb.size() != 0 || bus.ov_level != 0); n++)
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if (sb.size() != 0 || bus.ov_level != 0) begin
            errors++;
            $display("FAIL %s: %0d words outstanding, level %0d, expected 0 and 0",
                     name, sb.size(), bus.ov_level);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_valid"},    32'(bus.o_valid),    32'h0);
        chk({name, "_data"},     bus.ov_data,         32'h0);
        chk({name, "_keep"},     32'(bus.ov_keep),    32'h0);
        chk({name, "_level"},    32'(bus.ov_level),   32'h0);
        chk({name, "_overflow"}, 32'(bus.o_overflow), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid   = 1'b0;
        bus.iv_data   = 8'h00;
        bus.i_flush   = 1'b0;
        bus.i_ready   = 1'b0;
        bus.i_clr_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;

        // Full word, one-cycle latency, then empty again after the pop.
        bus.i_ready = 1'b1;
        expect_word(32'h44332211, 4'hF);
        word4(32'h44332211);
        chk("full_word_valid", 32'(bus.o_valid), 32'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("full_word_empty", 32'(bus.o_valid), 32'h0);

        // Partial flushes: flush alone, then flush carrying a byte.
        expect_word(32'h0000BBAA, 4'h3);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        cyc(1'b1, 8'hBB, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        expect_word(32'h00CCBBAA, 4'h7);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        cyc(1'b1, 8'hBB, 1'b0, 1'b0);
        cyc(1'b1, 8'hCC, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        drain("drain_flush");

        // Backpressure: fill, hold head stable, drop a fifth word.
        bus.i_ready = 1'b0;
        expect_word(32'h13121110, 4'hF);
        expect_word(32'h23222120, 4'hF);
        expect_word(32'h33323130, 4'hF);
        expect_word(32'h43424140, 4'hF);
        word4(32'h13121110);
        word4(32'h23222120);
        word4(32'h33323130);
        word4(32'h43424140);
        chk("bp_level", 32'(bus.ov_level), 32'h4);
        chk("bp_head", bus.ov_data, 32'h13121110);
        word4(32'h53525150);
        chk("bp_overflow", 32'(bus.o_overflow), 32'h1);
        chk("bp_level_after_drop", 32'(bus.ov_level), 32'h4);
        chk("bp_head_stable", bus.ov_data, 32'h13121110);
        drain("drain_bp");

        // Clear with no drop.
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", 32'(bus.o_overflow), 32'h0);

        // Full FIFO with a pop in the same cycle as the fifth commit.
        bus.i_ready = 1'b0;
        expect_word(32'h63626160, 4'hF);
        expect_word(32'h73727170, 4'hF);
        expect_word(32'h83828180, 4'hF);
        expect_word(32'h93929190, 4'hF);
        expect_word(32'hA3A2A1A0, 4'hF);
        word4(32'h63626160);
        word4(32'h73727170);
        word4(32'h83828180);
        word4(32'h93929190);
        cyc(1'b1, 8'hA0, 1'b0, 1'b0);
        cyc(1'b1, 8'hA1, 1'b0, 1'b0);
        cyc(1'b1, 8'hA2, 1'b0, 1'b0);
        bus.i_ready = 1'b1;
        cyc(1'b1, 8'hA3, 1'b0, 1'b0);
        bus.i_ready = 1'b0;
        chk("simul_level", 32'(bus.ov_level), 32'h4);
        chk("simul_overflow", 32'(bus.o_overflow), 32'h0);
        drain("drain_simul");

        // Drop and clear in the same cycle: set wins.
        bus.i_ready = 1'b0;
        expect_word(32'h000000C1, 4'h1);
        expect_word(32'h000000C2, 4'h1);
        expect_word(32'h000000C3, 4'h1);
        expect_word(32'h000000C4, 4'h1);
        cyc(1'b1, 8'hC1, 1'b1, 1'b0);
        cyc(1'b1, 8'hC2, 1'b1, 1'b0);
        cyc(1'b1, 8'hC3, 1'b1, 1'b0);
        cyc(1'b1, 8'hC4, 1'b1, 1'b0);
        cyc(1'b1, 8'hC5, 1'b1, 1'b1);
        chk("race_overflow", 32'(bus.o_overflow), 32'h1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("race_clear", 32'(bus.o_overflow), 32'h0);
        drain("drain_race");

        // Reset mid-operation: buffered words and a partial word are discarded.
        bus.i_ready = 1'b0;
        cyc(1'b1, 8'hE1, 1'b1, 1'b0);
        cyc(1'b1, 8'hE2, 1'b1, 1'b0);
        cyc(1'b1, 8'hF1, 1'b0, 1'b0);
        cyc(1'b1, 8'hF2, 1'b0, 1'b0);
        cyc(1'b1, 8'hF3, 1'b0, 1'b0);
        chk("pre_reset_level", 32'(bus.ov_level), 32'h2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("mid_reset");
        rst = 1'b0;
        bus.i_ready = 1'b1;
        expect_word(32'h04030201, 4'hF);
        word4(32'h04030201);
        drain("drain_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
